// File: rtl/eprisc_bus_arbiter.sv
// Two-requester round-robin owner of the epRISC byte-wide bus master; one full transaction per grant.
// Optional requester-0 priority while the bus interrupt is high: define EPRISC_BUSARB_IRQPRIO_EN.
module eprisc_bus_arbiter #(
    parameter int CLKDIV = 2,
    parameter int SETUP  = 1,
    parameter int GAP    = 2
) (
    input  logic       iBoardClock,
    input  logic       iBoardReset,
    input  logic       iReq0Valid,
    input  logic       iReq0Device,
    input  logic [0:7] iReq0Command,
    input  logic [0:7] iReq0Data,
    output logic       oReq0Ack,
    input  logic       iReq1Valid,
    input  logic       iReq1Device,
    input  logic [0:7] iReq1Command,
    input  logic [0:7] iReq1Data,
    output logic       oReq1Ack,
    output logic       oRspValid,
    output logic       oRspOwner,
    output logic [0:7] oRspData,
    output logic       oBusy,
    output logic       oBusClock,
    output logic [0:1] oBusSelect,
    output logic [0:7] oBusMOSI,
    input  logic [0:7] iBusMISO,
    input  logic       iBusInterrupt
);

    // state  | meaning
    // sIdle  | bus idle, waiting for a request
    // sSetup | select asserted, command on MOSI, bus clock low
    // sLow   | bus clock low half of the current byte
    // sHigh  | bus clock high half; MISO captured at the end of byte 1
    // sGap   | select released, response pulsed, bus recovery
    typedef enum logic [2:0] {sIdle, sSetup, sLow, sHigh, sGap} stateT;

    localparam int TW = 16;
    localparam logic [TW-1:0] DIVLOAD   = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] SETUPLOAD = TW'(SETUP - 1);
    localparam logic [TW-1:0] GAPLOAD   = TW'(GAP - 1);

    stateT         state;
    logic [TW-1:0] tmr;
    logic          byteSel;
    logic          owner;
    logic [0:7]    dataReg;
    logic          lastGrant;

    logic          anyReq;
    logic          tmrDone;
    logic          doGrant;
    logic          winner;
    logic          updPtr;

`ifdef EPRISC_BUSARB_IRQPRIO_EN
    logic [1:0] irqSync;

    always_ff @(posedge iBoardClock) begin
        if (!iBoardReset) begin
            irqSync <= 2'b00;
        end else begin
            irqSync <= {irqSync[0], iBusInterrupt};
        end
    end
`else
    logic unusedIrq;
    assign unusedIrq = iBusInterrupt;
`endif

    assign anyReq  = iReq0Valid | iReq1Valid;
    assign tmrDone = (tmr == '0);
    // The last GAP cycle doubles as an IDLE sample so back-to-back grants keep select high for exactly GAP cycles.
    assign doGrant = anyReq && ((state == sIdle) || ((state == sGap) && tmrDone));

    always_comb begin
        winner = iReq1Valid & ~iReq0Valid;
        updPtr = 1'b1;
        if (iReq0Valid && iReq1Valid) begin
            winner = ~lastGrant;
`ifdef EPRISC_BUSARB_IRQPRIO_EN
            if (irqSync[1]) begin
                winner = 1'b0;
                updPtr = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge iBoardClock) begin
        if (!iBoardReset) begin
            state      <= sIdle;
            tmr        <= '0;
            byteSel    <= 1'b0;
            owner      <= 1'b0;
            dataReg    <= '0;
            lastGrant  <= 1'b1;
            oReq0Ack   <= 1'b0;
            oReq1Ack   <= 1'b0;
            oRspValid  <= 1'b0;
            oRspOwner  <= 1'b0;
            oRspData   <= '0;
            oBusy      <= 1'b0;
            oBusClock  <= 1'b0;
            oBusSelect <= 2'b11;
            oBusMOSI   <= '0;
        end else begin
            oReq0Ack  <= 1'b0;
            oReq1Ack  <= 1'b0;
            oRspValid <= 1'b0;

            case (state)
                sIdle: begin
                end
                sSetup: begin
                    if (tmrDone) begin
                        state <= sLow;
                        tmr   <= DIVLOAD;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                sLow: begin
                    if (tmrDone) begin
                        state     <= sHigh;
                        oBusClock <= 1'b1;
                        tmr       <= DIVLOAD;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                sHigh: begin
                    if (tmrDone) begin
                        oBusClock <= 1'b0;
                        if (!byteSel) begin
                            state    <= sLow;
                            byteSel  <= 1'b1;
                            oBusMOSI <= dataReg;
                            tmr      <= DIVLOAD;
                        end else begin
                            state      <= sGap;
                            oBusSelect <= 2'b11;
                            oBusMOSI   <= '0;
                            oRspValid  <= 1'b1;
                            oRspOwner  <= owner;
                            oRspData   <= iBusMISO;
                            tmr        <= GAPLOAD;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                sGap: begin
                    if (tmrDone) begin
                        state <= sIdle;
                        oBusy <= 1'b0;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: begin
                    state <= sIdle;
                end
            endcase

            if (doGrant) begin
                state     <= sSetup;
                tmr       <= SETUPLOAD;
                byteSel   <= 1'b0;
                owner     <= winner;
                oBusy     <= 1'b1;
                oBusClock <= 1'b0;
                if (updPtr) begin
                    lastGrant <= winner;
                end
                if (winner) begin
                    oReq1Ack   <= 1'b1;
                    dataReg    <= iReq1Data;
                    oBusMOSI   <= iReq1Command;
                    oBusSelect <= iReq1Device ? 2'b10 : 2'b01;
                end else begin
                    oReq0Ack   <= 1'b1;
                    dataReg    <= iReq0Data;
                    oBusMOSI   <= iReq0Command;
                    oBusSelect <= iReq0Device ? 2'b10 : 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Directed bench for eprisc_bus_arbiter: default-parameter instance plus a CLKDIV=1/SETUP=3/GAP=1 instance.
module tb_eprisc_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2;
    logic       req0Valid, req1Valid, req0Valid2, req1Valid2;
    logic       req0Device, req1Device;
    logic [0:7] req0Command, req0Data, req1Command, req1Data;
    logic [0:7] miso;
    logic       irq;

    logic       ack0, ack1, rspValid, rspOwner, busy, busClock;
    logic [0:7] rspData, mosi;
    logic [0:1] sel;

    logic       ack0b, ack1b, rv2, own2, busy2, clk2;
    logic [0:7] data2, mosi2;
    logic [0:1] sel2;

    int nCompared = 0;
    int nFailed   = 0;
    int cyc       = 0;

    eprisc_bus_arbiter dut (
        .iBoardClock(clk), .iBoardReset(rst),
        .iReq0Valid(req0Valid), .iReq0Device(req0Device), .iReq0Command(req0Command),
        .iReq0Data(req0Data), .oReq0Ack(ack0),
        .iReq1Valid(req1Valid), .iReq1Device(req1Device), .iReq1Command(req1Command),
        .iReq1Data(req1Data), .oReq1Ack(ack1),
        .oRspValid(rspValid), .oRspOwner(rspOwner), .oRspData(rspData), .oBusy(busy),
        .oBusClock(busClock), .oBusSelect(sel), .oBusMOSI(mosi), .iBusMISO(miso),
        .iBusInterrupt(irq)
    );

    eprisc_bus_arbiter #(.CLKDIV(1), .SETUP(3), .GAP(1)) dut2 (
        .iBoardClock(clk), .iBoardReset(rst2),
        .iReq0Valid(req0Valid2), .iReq0Device(req0Device), .iReq0Command(req0Command),
        .iReq0Data(req0Data), .oReq0Ack(ack0b),
        .iReq1Valid(req1Valid2), .iReq1Device(req1Device), .iReq1Command(req1Command),
        .iReq1Data(req1Data), .oReq1Ack(ack1b),
        .oRspValid(rv2), .oRspOwner(own2), .oRspData(data2), .oBusy(busy2),
        .oBusClock(clk2), .oBusSelect(sel2), .oBusMOSI(mosi2), .iBusMISO(miso),
        .iBusInterrupt(irq)
    );

    typedef struct packed {
        logic        vld0;
        logic [7:0]  miso;
        logic [23:0] exp;
    } vecT;

    vecT vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mk(logic a0, logic a1, logic [1:0] s, logic c, logic [7:0] m,
                                       logic rv, logic ow, logic [7:0] d, logic b);
        return {a0, a1, s, c, m, rv, ow, d, b};
    endfunction

    function automatic logic [23:0] obs();
        return {ack0, ack1, sel, busClock, mosi, rspValid, rspValid & rspOwner, rspData, busy};
    endfunction

    task automatic waitAck(input string name, output logic who, output int at);
        bit got;
        got = 1'b0;
        who = 1'b0;
        at  = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (ack0 || ack1) begin
                got = 1'b1;
                who = ack1;
                at  = cyc;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    task automatic waitIdle(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (!busy) got = 1'b1;
        end
        check(name, 64'(got), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic who, who2;
        int   t1, t2, highCnt;
        bit   got, rspSeen;
        int   nAck, nRsp, selLow, run, maxRun, rvAt;
        int   ackAt [4];
        int   rspAt [4];
        logic ackWho [4];
        logic rspWho [4];
        logic [8:0] rspD;
        logic ack1bSeen;

        rst = 1'b0; rst2 = 1'b0;
        req0Valid = 1'b0; req1Valid = 1'b0; req0Valid2 = 1'b0; req1Valid2 = 1'b0;
        req0Device = 1'b1; req0Command = 8'hA5; req0Data = 8'h3C;
        req1Device = 1'b0; req1Command = 8'h11; req1Data = 8'h22;
        miso = 8'h00; irq = 1'b0;

        // Single request, one row per cycle starting at the ack cycle T.
        vecs[0]  = '{1'b1, 8'h00, mk(1, 0, 2'b10, 0, 8'hA5, 0, 0, 8'h00, 1)};
        vecs[1]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 0, 8'hA5, 0, 0, 8'h00, 1)};
        vecs[2]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 0, 8'hA5, 0, 0, 8'h00, 1)};
        vecs[3]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 1, 8'hA5, 0, 0, 8'h00, 1)};
        vecs[4]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 1, 8'hA5, 0, 0, 8'h00, 1)};
        vecs[5]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 0, 8'h3C, 0, 0, 8'h00, 1)};
        vecs[6]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 0, 8'h3C, 0, 0, 8'h00, 1)};
        vecs[7]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 1, 8'h3C, 0, 0, 8'h00, 1)};
        vecs[8]  = '{1'b0, 8'h00, mk(0, 0, 2'b10, 1, 8'h3C, 0, 0, 8'h00, 1)};
        vecs[9]  = '{1'b0, 8'h5A, mk(0, 0, 2'b11, 0, 8'h00, 1, 0, 8'h5A, 1)};
        vecs[10] = '{1'b0, 8'hFF, mk(0, 0, 2'b11, 0, 8'h00, 0, 0, 8'h5A, 1)};
        vecs[11] = '{1'b0, 8'hFF, mk(0, 0, 2'b11, 0, 8'h00, 0, 0, 8'h5A, 0)};

        step();
        step();
        check("reset", 64'(obs()), 64'(mk(0, 0, 2'b11, 0, 8'h00, 0, 0, 8'h00, 0)));
        rst = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            req0Valid = vecs[i].vld0;
            miso      = vecs[i].miso;
            step();
            check($sformatf("single_%0d", i), 64'(obs()), 64'(vecs[i].exp));
        end

        // Back-to-back requester 1, device 0.
        miso = 8'h77;
        req1Valid = 1'b1;
        waitAck("b2b_ack1", who, t1);
        check("b2b_who1", 64'(who), 64'd1);
        check("b2b_sel", 64'(sel), 64'(2'b01));
        req1Valid = 1'b0;
        step();
        req1Valid = 1'b1;
        got = 1'b0; rspSeen = 1'b0; highCnt = 0; t2 = 0; who2 = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (rspValid) begin
                rspSeen = 1'b1;
                check("b2b_rsp", 64'({rspOwner, rspData}), 64'({1'b1, 8'h77}));
            end
            if (ack0 || ack1) begin
                got = 1'b1; t2 = cyc; who2 = ack1;
            end else if (sel == 2'b11) begin
                highCnt++;
            end
        end
        check("b2b_rsp_seen", 64'(rspSeen), 64'd1);
        check("b2b_who2", 64'(who2), 64'd1);
        check("b2b_spacing", 64'(t2 - t1), 64'd11);
        check("b2b_sel_high", 64'(highCnt), 64'd2);
        req1Valid = 1'b0;
        waitIdle("b2b_idle");

        // Reset during byte 0 HIGH, then continuous contention.
        req0Valid = 1'b1;
        waitAck("rst_ack", who, t1);
        req0Valid = 1'b0;
        step(); step(); step();
        check("rst_mid_high", 64'(busClock), 64'd1);
        rst = 1'b0;
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        step();
        check("rst_abort", 64'(obs()), 64'(mk(0, 0, 2'b11, 0, 8'h00, 0, 0, 8'h00, 0)));
        step();
        check("rst_hold", 64'(obs()), 64'(mk(0, 0, 2'b11, 0, 8'h00, 0, 0, 8'h00, 0)));
        rst = 1'b1;

        nAck = 0; nRsp = 0;
        for (int k = 0; k < 4; k++) begin
            ackAt[k] = 0; rspAt[k] = 0; ackWho[k] = 1'bx; rspWho[k] = 1'bx;
        end
        for (int i = 0; i < 80 && nRsp < 4; i++) begin
            step();
            if (ack0 && ack1) check("cont_double_ack", 64'({ack0, ack1}), 64'd0);
            if ((ack0 || ack1) && nAck < 4) begin
                ackWho[nAck] = ack1; ackAt[nAck] = cyc; nAck++;
            end
            if (rspValid && nRsp < 4) begin
                rspWho[nRsp] = rspOwner; rspAt[nRsp] = cyc; nRsp++;
            end
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        check("cont_nrsp", 64'(nRsp), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cont_grant_%0d", k), 64'(ackWho[k]), 64'(k % 2));
            check($sformatf("cont_owner_%0d", k), 64'(rspWho[k]), 64'(k % 2));
            check($sformatf("cont_rsplat_%0d", k), 64'(rspAt[k] - ackAt[k]), 64'd9);
            if (k > 0) check($sformatf("cont_spacing_%0d", k), 64'(ackAt[k] - ackAt[k-1]), 64'd11);
        end
        waitIdle("cont_idle");

        // Leave the pointer favouring requester 1, then contend with the interrupt high.
        req0Valid = 1'b1;
        waitAck("irq_prep_ack", who, t1);
        check("irq_prep_who", 64'(who), 64'd0);
        req0Valid = 1'b0;
        waitIdle("irq_prep_idle");
        irq = 1'b1;
        step(); step(); step();
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        waitAck("irq_ack_a", who, t1);
        waitAck("irq_ack_b", who2, t2);
        req0Valid = 1'b0;
        req1Valid = 1'b0;
`ifdef EPRISC_BUSARB_IRQPRIO_EN
        check("irq_grant_a", 64'(who), 64'd0);
        check("irq_grant_b", 64'(who2), 64'd0);
`else
        check("irq_grant_a", 64'(who), 64'd1);
        check("irq_grant_b", 64'(who2), 64'd0);
`endif
        check("irq_spacing", 64'(t2 - t1), 64'd11);
        irq = 1'b0;
        waitIdle("irq_idle");

        // CLKDIV=1, SETUP=3, GAP=1 instance.
        req0Device = 1'b0; req0Command = 8'h96; req0Data = 8'h69; miso = 8'hC3;
        rst2 = 1'b1;
        step();
        req0Valid2 = 1'b1;
        got = 1'b0; t1 = 0; ack1bSeen = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (ack0b) begin got = 1'b1; t1 = cyc; end
        end
        check("sweep_ack", 64'(got), 64'd1);
        check("sweep_mosi", 64'(mosi2), 64'h96);
        req0Valid2 = 1'b0;
        selLow = 0; highCnt = 0; run = 0; maxRun = 0; rvAt = -1; rspD = '0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            if (ack1b) ack1bSeen = 1'b1;
            if (sel2 != 2'b11) selLow++;
            if (clk2) begin
                highCnt++; run++;
                if (run > maxRun) maxRun = run;
            end else begin
                run = 0;
            end
            if (rv2 && rvAt < 0) begin
                rvAt = cyc - t1;
                rspD = {own2, data2};
            end
            if (i == 8) check("sweep_busy_drop", 64'(busy2), 64'd0);
        end
        check("sweep_sel_low", 64'(selLow), 64'd7);
        check("sweep_clk_high", 64'(highCnt), 64'd2);
        check("sweep_clk_run", 64'(maxRun), 64'd1);
        check("sweep_rsp_at", 64'(rvAt), 64'd7);
        check("sweep_rsp", 64'(rspD), 64'({1'b0, 8'hC3}));
        check("sweep_no_ack1", 64'(ack1bSeen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
